interp_tile_stepper: RTL and testbench

//  Per-tile pixel sequencer that sits directly upstream of the plane interpolator (interp).
//  On start it holds the interpolator's setup window open for a fixed number of cycles, then walks every pixel of one tile in raster order.
//  It drives x_ps/y_ps into interp and forwards each interpolated value downstream on a valid/ready stream with its in-tile coordinates.

---
 rtl/interp_tile_stepper.sv | 122 ++++++++++++
 tb/tb_interp_tile_stepper.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/interp_tile_stepper.sv
// Per-tile pixel sequencer in front of interp: holds setup for SETTLE cycles, then walks the tile in raster order.
// Optional macro INTERP_Z_CLAMP_EN: clamps negative interpolated values to zero on pix_z.
module interp_tile_stepper #(
   parameter int TILE_W = 32,
   parameter int TILE_H = 32,
   parameter int SETTLE = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [5:0]  tile_x,
   input  logic [5:0]  tile_y,
   output logic        busy,
   output logic        done,
   output logic        setup,
   output logic [10:0] x_ps,
   output logic [10:0] y_ps,
   input  logic [31:0] interp_in,
   output logic        pix_valid,
   input  logic        pix_ready,
   output logic [4:0]  pix_x,
   output logic [4:0]  pix_y,
   output logic [31:0] pix_z
);

   // Stream contract: a beat transfers on a clock edge where pix_valid && pix_ready;
   // pix_valid stays high in WALK regardless of pix_ready and coordinates hold while stalled.

   typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_WALK, ST_DONE} state_t;

   localparam logic [4:0]  PX_LAST   = 5'(TILE_W - 1);
   localparam logic [4:0]  PY_LAST   = 5'(TILE_H - 1);
   localparam logic [10:0] W11       = 11'(TILE_W);
   localparam logic [10:0] H11       = 11'(TILE_H);
   localparam logic [3:0]  SETTLE_LD = 4'(SETTLE - 1);

   state_t     state;
   logic [3:0] settle_cnt;
   logic [5:0] tx_q;
   logic [5:0] ty_q;

   // Screen coordinate = tile index * tile size + in-tile offset, modulo 2048.
   function automatic logic [10:0] scr(input logic [5:0] t, input logic [10:0] sz,
                                       input logic [4:0] p);
      return 11'({5'd0, t} * sz) + {6'd0, p};
   endfunction

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= ST_IDLE;
         settle_cnt <= 4'd0;
         tx_q       <= 6'd0;
         ty_q       <= 6'd0;
         busy       <= 1'b0;
         done       <= 1'b0;
         setup      <= 1'b0;
         pix_valid  <= 1'b0;
         x_ps       <= 11'd0;
         y_ps       <= 11'd0;
         pix_x      <= 5'd0;
         pix_y      <= 5'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state      <= ST_SETTLE;
                  busy       <= 1'b1;
                  setup      <= 1'b1;
                  tx_q       <= tile_x;
                  ty_q       <= tile_y;
                  pix_x      <= 5'd0;
                  pix_y      <= 5'd0;
                  x_ps       <= scr(tile_x, W11, 5'd0);
                  y_ps       <= scr(tile_y, H11, 5'd0);
                  settle_cnt <= SETTLE_LD;
               end
            end
            ST_SETTLE: begin
               if (settle_cnt == 4'd0) begin
                  state     <= ST_WALK;
                  setup     <= 1'b0;
                  pix_valid <= 1'b1;
               end else begin
                  settle_cnt <= settle_cnt - 4'd1;
               end
            end
            ST_WALK: begin
               if (pix_valid && pix_ready) begin
                  // The final beat leaves the coordinates on the last pixel rather than wrapping.
                  if (pix_x == PX_LAST && pix_y == PY_LAST) begin
                     state     <= ST_DONE;
                     pix_valid <= 1'b0;
                     done      <= 1'b1;
                  end else if (pix_x == PX_LAST) begin
                     pix_x <= 5'd0;
                     pix_y <= pix_y + 5'd1;
                     x_ps  <= scr(tx_q, W11, 5'd0);
                     y_ps  <= scr(ty_q, H11, pix_y + 5'd1);
                  end else begin
                     pix_x <= pix_x + 5'd1;
                     x_ps  <= scr(tx_q, W11, pix_x + 5'd1);
                  end
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef INTERP_Z_CLAMP_EN
   assign pix_z = interp_in[31] ? 32'd0 : interp_in;
`else
   assign pix_z = interp_in;
`endif

endmodule

// File: tb/tb_interp_tile_stepper.sv
// Directed bench for interp_tile_stepper: table of tiles plus reset-abort and clamp sequences.
module tb_interp_tile_stepper;

   logic        clock = 1'b0;
   logic        reset, start, pix_ready;
   logic [5:0]  tile_x, tile_y;
   logic        busy, done, setup, pix_valid;
   logic [10:0] x_ps, y_ps;
   logic [31:0] interp_in, pix_z;
   logic [4:0]  pix_x, pix_y;
   logic        ovr;
   logic [31:0] ovr_val;

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_q[$];

   interp_tile_stepper dut (
      .clock(clock), .reset(reset), .start(start), .tile_x(tile_x), .tile_y(tile_y),
      .busy(busy), .done(done), .setup(setup), .x_ps(x_ps), .y_ps(y_ps),
      .interp_in(interp_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
      .pix_x(pix_x), .pix_y(pix_y), .pix_z(pix_z)
   );

   always #5 clock = ~clock;

   // Stand-in interpolator: value encodes the screen coordinates, always non-negative.
   function automatic logic [31:0] zmodel(input logic [10:0] x, input logic [10:0] y);
      return {5'd0, x, 5'd0, y};
   endfunction

   assign interp_in = ovr ? ovr_val : zmodel(x_ps, y_ps);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [5:0]  tx, ty;
      bit          stall, poke;
      logic [10:0] e_fx, e_fy, e_lx, e_ly, e_sx;
      int          e_done;
   } vec_t;

   vec_t vecs[5];

   // Called at a negedge with the DUT in IDLE; returns at the negedge after the done cycle.
   task automatic run_tile(input vec_t v);
      int beats = 0, done_cyc = -1, stall_n = 0;
      logic [31:0] last = 32'd0, got;
      exp_q.delete();
      for (int py = 0; py < 32; py++)
         for (int px = 0; px < 32; px++)
            exp_q.push_back({5'(px), 5'(py), 11'({5'd0, v.tx} * 11'd32 + 11'(px)),
                             11'({5'd0, v.ty} * 11'd32 + 11'(py))});
      tile_x = v.tx; tile_y = v.ty; start = 1'b1; pix_ready = 1'b1;
      @(negedge clock);
      for (int c = 1; c < 3000 && done_cyc < 0; c++) begin
         start = 1'b0;
         if (v.poke && (c == 1 || c == 100)) begin
            start = 1'b1; tile_x = 6'd9; tile_y = 6'd9;
         end
         if (c <= 2) begin
            chk("settle_setup", {31'd0, setup}, 32'd1);
            chk("settle_valid", {31'd0, pix_valid}, 32'd0);
         end
         if (c == 3) begin
            chk("first_valid", {31'd0, pix_valid}, 32'd1);
            chk("first_setup", {31'd0, setup}, 32'd0);
            chk("first_x_ps", {21'd0, x_ps}, {21'd0, v.e_fx});
            chk("first_y_ps", {21'd0, y_ps}, {21'd0, v.e_fy});
         end
         if (done) begin
            done_cyc = c;
            if (v.poke) start = 1'b1;
         end
         pix_ready = !(v.stall && beats == 10 && stall_n < 5);
         if (!pix_ready) begin
            stall_n++;
            chk("stall_valid", {31'd0, pix_valid}, 32'd1);
            chk("stall_x_ps", {21'd0, x_ps}, {21'd0, v.e_sx});
            chk("stall_pix_x", {27'd0, pix_x}, 32'd10);
            chk("stall_pix_z", pix_z, zmodel(v.e_sx, v.e_fy));
         end
         if (pix_valid && pix_ready) begin
            got = {pix_x, pix_y, x_ps, y_ps};
            if (exp_q.size() == 0) begin
               chk("extra_beat", got, 32'd0);
            end else begin
               last = exp_q.pop_front();
               chk("beat", got, last);
               chk("beat_z", pix_z, zmodel(last[21:11], last[10:0]));
            end
            beats++;
         end
         @(negedge clock);
      end
      start = 1'b0;
      chk("done_cycle", 32'(done_cyc), 32'(v.e_done));
      chk("beat_count", 32'(beats), 32'd1024);
      chk("last_x_ps", {21'd0, last[21:11]}, {21'd0, v.e_lx});
      chk("last_y_ps", {21'd0, last[10:0]}, {21'd0, v.e_ly});
      chk("idle_busy", {31'd0, busy}, 32'd0);
      chk("idle_done", {31'd0, done}, 32'd0);
   endtask

   initial begin
      int beats;
      bit saw;
      vecs[0] = '{tx: 6'd2,  ty: 6'd3,  stall: 0, poke: 0, e_fx: 11'd64,   e_fy: 11'd96,
                  e_lx: 11'd95,   e_ly: 11'd127,  e_sx: 11'd74,  e_done: 1027};
      vecs[1] = '{tx: 6'd2,  ty: 6'd3,  stall: 1, poke: 1, e_fx: 11'd64,   e_fy: 11'd96,
                  e_lx: 11'd95,   e_ly: 11'd127,  e_sx: 11'd74,  e_done: 1032};
      vecs[2] = '{tx: 6'd63, ty: 6'd63, stall: 0, poke: 0, e_fx: 11'd2016, e_fy: 11'd2016,
                  e_lx: 11'd2047, e_ly: 11'd2047, e_sx: 11'd2026, e_done: 1027};
      vecs[3] = '{tx: 6'd0,  ty: 6'd0,  stall: 0, poke: 0, e_fx: 11'd0,    e_fy: 11'd0,
                  e_lx: 11'd31,   e_ly: 11'd31,   e_sx: 11'd10,  e_done: 1027};
      vecs[4] = '{tx: 6'd5,  ty: 6'd1,  stall: 1, poke: 0, e_fx: 11'd160,  e_fy: 11'd32,
                  e_lx: 11'd191,  e_ly: 11'd63,   e_sx: 11'd170, e_done: 1032};

      // Clock/reset
      reset = 1'b1; start = 1'b0; pix_ready = 1'b0; tile_x = 6'd0; tile_y = 6'd0;
      ovr = 1'b0; ovr_val = 32'd0;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_setup", {31'd0, setup}, 32'd0);
      chk("rst_valid", {31'd0, pix_valid}, 32'd0);
      chk("rst_x_ps", {21'd0, x_ps}, 32'd0);
      chk("rst_y_ps", {21'd0, y_ps}, 32'd0);
      chk("rst_pix_xy", {22'd0, pix_x, pix_y}, 32'd0);
      repeat (20) begin
         @(negedge clock);
         chk("idle_hold", {30'd0, busy, pix_valid}, 32'd0);
      end

      // Tile table; consecutive entries start the cycle right after the previous done.
      foreach (vecs[i]) run_tile(vecs[i]);

      // Reset abort at beat 500, with a negative-value check on the way.
      tile_x = 6'd1; tile_y = 6'd1; start = 1'b1; pix_ready = 1'b1;
      beats = 0;
      for (int c = 0; c < 2000 && beats < 500; c++) begin
         @(negedge clock);
         start = 1'b0;
         if (beats == 200) begin
            ovr = 1'b1; ovr_val = 32'hFFFFFFFB;
            #1;
`ifdef INTERP_Z_CLAMP_EN
            chk("clamp_neg", pix_z, 32'd0);
`else
            chk("pass_neg", pix_z, 32'hFFFFFFFB);
`endif
            ovr = 1'b0;
            #1;
         end
         if (pix_valid && pix_ready) beats++;
      end
      chk("abort_reached", 32'(beats), 32'd500);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_valid", {31'd0, pix_valid}, 32'd0);
      chk("abort_setup_done", {30'd0, setup, done}, 32'd0);
      chk("abort_x_ps", {21'd0, x_ps}, 32'd0);
      chk("abort_y_ps", {21'd0, y_ps}, 32'd0);
      chk("abort_pix_xy", {22'd0, pix_x, pix_y}, 32'd0);
      saw = 1'b0;
      repeat (5) begin
         @(negedge clock);
         if (done || busy) saw = 1'b1;
      end
      chk("abort_quiet", {31'd0, saw}, 32'd0);
      run_tile(vecs[3]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
